stim_cmd_parser: RTL
====================

# stim_cmd_parser

Command-frame decoder on the host side of the stimulation pulse path. Consumes the byte stream delivered by the UART receiver (`rx_data`/`rx_valid`), validates framed stimulation commands and publishes a coherent parameter set (mode, pulse frequency, burst frequency, IGBT on-time) to the pulse logic generator. Sits between the UART RX block and the IGBT/SCR pulse generators. Parameters change only on a fully validated frame.

## Interface
- `TIMEOUT_CYC`, default 500000: inter-byte timeout in `sys_clk` cycles (10 ms at 50 MHz).
- `MAX_PULSE_HZ`, default 100: upper limit for the pulse frequency.
- `MAX_ON_US`, default 1000: upper limit for the IGBT on-time, in µs.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst` in 1: reset; one clock, reset asynchronous and active-high.
- `rx_data` in 8: received byte, valid only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `stimulate_mod` out 4: committed mode.
- `pulses_frequency` out 12: committed pulse frequency, Hz.
- `burst_frequency` out 12: committed burst frequency, Hz.
- `igbt_on_time` out 24: committed IGBT on-time, µs.
- `param_valid` out 1: one-cycle strobe when new parameters are committed.
- `frame_err` out 1: one-cycle strobe on a rejected frame.
- `err_code` out 3: cause of the last error; holds until the next error.
- `busy` out 1: high while a frame is in progress, which is any state other than IDLE.

## Operation
- Frame format, 11 bytes: 0xAA, 0x55, MODE, PF_H, PF_L, BF_H, BF_L, OT_H, OT_M, OT_L, CKS.
- CKS is the 8-bit sum, modulo 256, of the 8 payload bytes MODE through OT_L.
- State machine:
  - IDLE: on 0xAA go to HDR2; any other byte is ignored.
  - HDR2: on 0x55 go to PAYLOAD with index 0. On 0xAA stay in HDR2. On any other byte go to IDLE, with no error.
  - PAYLOAD: store the byte at the current index and accumulate the sum. After index 7, go to CHECK.
  - CHECK: on the CKS byte, validate the frame, then commit or raise an error. Return to IDLE either way.
- Validation order (first failure wins, and sets `err_code`):
  1. Checksum mismatch: code 1.
  2. MODE > 4: code 2. Valid modes are 0 idle, 1 single pulse, 2 rTMS, 3 TBS/burst, 4 test.
  3. Range violation: code 3. For MODE ≠ 0 this is any of:
     - PF_H[7:4] or BF_H[7:4] nonzero.
     - pulse frequency 0 or > MAX_PULSE_HZ.
     - on-time 0 or > MAX_ON_US.
     - MODE = 3 with burst frequency 0.
  4. Inter-byte timeout: code 4 (see Configuration).
- Commit: all four outputs load together from the shadow registers, so downstream logic never sees a mixed set.
- A MODE 0 frame commits mode 0 and skips the range check. The numeric fields still load.
- On an error the outputs keep their previous committed values.

## Timing
- Reset values: `stimulate_mod`=0, both frequencies=0, `igbt_on_time`=0, `param_valid`=0, `frame_err`=0, `err_code`=0, `busy`=0, state IDLE.
- Latency: `param_valid` or `frame_err` is high exactly one cycle after the `sys_clk` edge that samples the CKS byte with `rx_valid`=1. Outputs show the new values in that same cycle.
- `param_valid` and `frame_err` are never high together. They are never high for two consecutive cycles unless two frames complete back to back.
- Back-to-back bytes on every cycle are accepted; the block has no backpressure.
- A byte arriving in the cycle the strobe is issued starts the next frame from IDLE.
- Reset asserted mid-frame: the partial frame is discarded and all outputs return to their reset values immediately, since reset is asynchronous.

## Configuration
- `STIM_PARSER_TIMEOUT_EN` defined:
  - A counter runs while state ≠ IDLE and clears on every `rx_valid`.
  - When it reaches TIMEOUT_CYC with no `rx_valid` in that cycle: `frame_err`=1, `err_code`=4, state goes to IDLE.
  - If `rx_valid` arrives in the same cycle, the byte wins and no timeout is raised.
- `STIM_PARSER_TIMEOUT_EN` undefined: no counter. A partial frame waits indefinitely, and code 4 is never produced.

## Structure
- Package `stim_pkg`:
  - header constants 0xAA/0x55 and frame length 11;
  - mode enum (IDLE, SINGLE, RTMS, TBS, TEST);
  - error-code enum (NONE, CKS, MODE, RANGE, TIMEOUT);
  - parser state enum.
- Sub-module `stim_param_check`: combinational range and mode validator. Takes the shadow fields and parameters; returns pass/fail plus an error code.

## Test plan
- Valid frame AA 55 02 00 0A 00 00 00 00 64 70 → one cycle after CKS: `param_valid`=1, mode=2, `pulses_frequency`=10, `igbt_on_time`=100.
- Same frame with CKS=71 → `frame_err`=1, `err_code`=1, outputs unchanged from the previous commit.
- MODE=3, PF=200 with a correct checksum → `err_code`=3. MODE=7 → `err_code`=2.
- AA AA 55 followed by a valid payload → accepted. AA 12 → silent return to IDLE, `busy`=0.
- With the macro defined, stop after 5 bytes for TIMEOUT_CYC cycles → `err_code`=4, then a fresh valid frame commits. Also check that a byte arriving exactly at expiry is accepted.
- Assert `sys_rst` after byte 6 → all outputs zero. A full valid frame after release commits normally.

Source files
------------

// File: rtl/stim_cmd_parser_pkg.sv
// Shared constants and types for the stimulation command parser: frame header
// bytes, frame length, mode / error-code / parser-state enums.
package stim_pkg;

  localparam logic [7:0] HDR_BYTE0   = 8'hAA;
  localparam logic [7:0] HDR_BYTE1   = 8'h55;
  localparam int         FRAME_LEN   = 11;
  localparam int         PAYLOAD_LEN = FRAME_LEN - 3;

  typedef enum logic [3:0] {
    MODE_IDLE   = 4'd0,
    MODE_SINGLE = 4'd1,
    MODE_RTMS   = 4'd2,
    MODE_TBS    = 4'd3,
    MODE_TEST   = 4'd4
  } mode_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CKS     = 3'd1,
    ERR_MODE    = 3'd2,
    ERR_RANGE   = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR2,
    ST_PAYLOAD,
    ST_CHECK
  } state_e;

endpackage

// File: rtl/stim_cmd_parser_if.sv
// Byte-stream input and committed-parameter output bundle of the parser.
// master = UART / host side, slave = parser.
interface stim_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  stimulate_mod;
  logic [11:0] pulses_frequency;
  logic [11:0] burst_frequency;
  logic [23:0] igbt_on_time;
  logic        param_valid;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  stimulate_mod, pulses_frequency, burst_frequency, igbt_on_time,
    input  param_valid, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output stimulate_mod, pulses_frequency, burst_frequency, igbt_on_time,
    output param_valid, frame_err, err_code, busy
  );
endinterface

// File: rtl/stim_cmd_parser_param_check.sv
// Combinational mode and range validator for a received payload.
// MODE 0 bypasses the range checks; the checksum is judged by the caller.
module stim_param_check
  import stim_pkg::*;
#(
  parameter int unsigned MAX_PULSE_HZ = 100,
  parameter int unsigned MAX_ON_US    = 1000
) (
  input  logic [7:0]  mode,
  input  logic [7:0]  pf_h,
  input  logic [7:0]  pf_l,
  input  logic [7:0]  bf_h,
  input  logic [7:0]  bf_l,
  input  logic [23:0] on_time,
  output logic        pass,
  output err_e        err
);

  localparam logic [11:0] MAX_PF = 12'(MAX_PULSE_HZ);
  localparam logic [23:0] MAX_OT = 24'(MAX_ON_US);

  logic [11:0] pf;
  logic [11:0] bf;
  logic        mode_ok;
  logic        range_bad;

  assign pf      = {pf_h[3:0], pf_l};
  assign bf      = {bf_h[3:0], bf_l};
  assign mode_ok = (mode[7:4] == 4'd0) && (mode[3:0] <= MODE_TEST);

  assign range_bad = (pf_h[7:4] != 4'd0) || (bf_h[7:4] != 4'd0)
                  || (pf == 12'd0) || (pf > MAX_PF)
                  || (on_time == 24'd0) || (on_time > MAX_OT)
                  || ((mode[3:0] == MODE_TBS) && (bf == 12'd0));

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves a value held, which would infer a latch.
  always_comb begin
    pass = 1'b1;
    err  = ERR_NONE;
    if (!mode_ok) begin
      pass = 1'b0;
      err  = ERR_MODE;
    end else if ((mode[3:0] != MODE_IDLE) && range_bad) begin
      pass = 1'b0;
      err  = ERR_RANGE;
    end
  end

endmodule

// File: rtl/stim_cmd_parser.sv
// Stimulation command-frame decoder: AA 55 + 8 payload bytes + checksum.
// Optional inter-byte timeout enabled by defining STIM_PARSER_TIMEOUT_EN.
module stim_cmd_parser
  import stim_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 500000,
  parameter int unsigned MAX_PULSE_HZ = 100,
  parameter int unsigned MAX_ON_US    = 1000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  stim_cmd_parser_if.slave   bus
);

  state_e      state, state_nxt;
  logic [2:0]  idx;
  logic [7:0]  sum;
  logic [7:0]  payload [PAYLOAD_LEN];

  logic        start_payload;
  logic        store_byte;
  logic        commit;
  logic        reject;
  err_e        err_nxt;
  logic        timeout_hit;

  logic        chk_pass;
  err_e        chk_err;

  logic [3:0]  mode_q;
  logic [11:0] pf_q;
  logic [11:0] bf_q;
  logic [23:0] ot_q;
  logic        param_valid_q;
  logic        frame_err_q;
  logic [2:0]  err_code_q;

  stim_param_check #(
    .MAX_PULSE_HZ (MAX_PULSE_HZ),
    .MAX_ON_US    (MAX_ON_US)
  ) u_check (
    .mode    (payload[0]),
    .pf_h    (payload[1]),
    .pf_l    (payload[2]),
    .bf_h    (payload[3]),
    .bf_l    (payload[4]),
    .on_time ({payload[5], payload[6], payload[7]}),
    .pass    (chk_pass),
    .err     (chk_err)
  );

`ifdef STIM_PARSER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts consecutive byte-less cycles inside a frame; the byte wins a tie.
  assign timeout_hit = (state != ST_IDLE) && !bus.rx_valid
                    && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      to_cnt <= '0;
    else if ((state == ST_IDLE) || bus.rx_valid || timeout_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    start_payload = 1'b0;
    store_byte    = 1'b0;
    commit        = 1'b0;
    reject        = 1'b0;
    err_nxt       = ERR_NONE;

    if (timeout_hit) begin
      state_nxt = ST_IDLE;
      reject    = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end else if (bus.rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (bus.rx_data == HDR_BYTE0) state_nxt = ST_HDR2;
        end
        ST_HDR2: begin
          if (bus.rx_data == HDR_BYTE1) begin
            state_nxt     = ST_PAYLOAD;
            start_payload = 1'b1;
          end else if (bus.rx_data != HDR_BYTE0) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          store_byte = 1'b1;
          if (idx == 3'(PAYLOAD_LEN - 1)) state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          state_nxt = ST_IDLE;
          if (bus.rx_data != sum) begin
            reject  = 1'b1;
            err_nxt = ERR_CKS;
          end else if (!chk_pass) begin
            reject  = 1'b1;
            err_nxt = chk_err;
          end else begin
            commit = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      sum           <= '0;
      mode_q        <= '0;
      pf_q          <= '0;
      bf_q          <= '0;
      ot_q          <= '0;
      param_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state         <= state_nxt;
      param_valid_q <= commit;
      frame_err_q   <= reject;
      if (reject) err_code_q <= err_nxt;

      if (start_payload) begin
        idx <= '0;
        sum <= '0;
      end else if (store_byte) begin
        idx <= idx + 3'd1;
        sum <= sum + bus.rx_data;
      end

      if (commit) begin
        mode_q <= payload[0][3:0];
        pf_q   <= {payload[1][3:0], payload[2]};
        bf_q   <= {payload[3][3:0], payload[4]};
        ot_q   <= {payload[5], payload[6], payload[7]};
      end
    end
  end

  // NOTE: the shadow bytes carry no reset; they are always fully rewritten
  // before CHECK can consult them, so a reset network would buy nothing.
  always_ff @(posedge sys_clk) begin
    if (store_byte) payload[idx] <= bus.rx_data;
  end

  assign bus.stimulate_mod    = mode_q;
  assign bus.pulses_frequency = pf_q;
  assign bus.burst_frequency  = bf_q;
  assign bus.igbt_on_time     = ot_q;
  assign bus.param_valid      = param_valid_q;
  assign bus.frame_err        = frame_err_q;
  assign bus.err_code         = err_code_q;
  assign bus.busy             = (state != ST_IDLE);

endmodule
